// File: rtl/fifo_rd_pkg.sv
// ============================================================================
//  Module      : fifo_rd_pkg
//  Description : Shared types and default sizes for the FIFO burst reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

    localparam int FIFO_RD_DATA_W    = 8;
    localparam int FIFO_RD_MAX_BURST = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_rd_out_stage.sv
// ============================================================================
//  Module      : fifo_rd_out_stage
//  Description : Single-entry data/last/valid holding register for the stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_out_stage
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = FIFO_RD_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              accept,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic              valid
);

    // A load wins over an accept in the same cycle so the stage sustains one beat per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            last  <= load_last;
            valid <= 1'b1;
        end else if (accept) begin
            last  <= 1'b0;
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Pops a programmed burst from the FIFO read port onto a
//                valid/ready stream with last marker and done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = FIFO_RD_DATA_W,
    parameter int MAX_BURST = FIFO_RD_MAX_BURST,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              rempty,
    input  logic [DATA_W-1:0] rdata,
    output logic              rinc,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

    rd_state_t        state;
    logic [LEN_W-1:0] remaining;
    logic             accept;
    logic             last_pop;

    assign accept   = m_valid & m_ready;
    assign last_pop = (remaining == LEN_W'(1));

    // Pop only when the holding register is free or is being drained this cycle.
    assign rinc = !rrst && (state == ST_RUN) && !rempty && (remaining != '0)
                  && (!m_valid || m_ready);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && (len != '0) && (len <= MAX_LEN)) begin
                        remaining <= len;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rinc) begin
                        remaining <= remaining - LEN_W'(1);
                        if (last_pop) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Only the final beat can still be held here.
                    if (accept && m_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    fifo_rd_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk       (rclk),
        .rst       (rrst),
        .load      (rinc),
        .accept    (accept),
        .load_data (rdata),
        .load_last (last_pop),
        .data      (m_data),
        .last      (m_last),
        .valid     (m_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Scoreboard bench for fifo_burst_reader with a behavioural FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;
    localparam int LEN_W     = $clog2(MAX_BURST + 1);

    logic              rclk = 1'b0;
    logic              rrst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              rempty;
    logic [DATA_W-1:0] rdata;
    logic              rinc;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural FIFO: written by stimulus, popped by the DUT.
    logic [DATA_W-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_ptr];

    always @(posedge rclk) begin
        if (rinc && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
    end

    // Expected beats: {last, data}
    logic [DATA_W:0] exp_q [$];

    int pop_total  = 0;
    int acc_total  = 0;
    int done_count = 0;

    always #5 rclk = ~rclk;

    fifo_burst_reader #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .LEN_W     (LEN_W)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .start   (start),
        .len     (len),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_fifo(input logic [DATA_W-1:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_beat(input logic [DATA_W-1:0] b, input logic l);
        exp_q.push_back({l, b});
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        d0 = done_count;
        for (int i = 0; i < budget; i++) begin
            @(negedge rclk);
            #1;
            if (done_count != d0) break;
        end
        if (done_count == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    // Monitor: scoreboard compare, hold stability, pop legality, done pulse width.
    initial begin : monitor
        logic            prev_hold;
        logic [DATA_W-1:0] prev_data;
        logic            prev_last;
        logic            prev_done;
        logic [DATA_W:0] e;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge rclk);
            if (!rrst) begin
                if (prev_hold) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data", 32'(m_data), 32'(prev_data));
                    check("hold_last", 32'(m_last), 32'(prev_last));
                end
                if (m_valid && m_ready) begin
                    acc_total++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h with no beat expected", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(m_data), 32'(e[DATA_W-1:0]));
                        check("beat_last", 32'(m_last), 32'(e[DATA_W]));
                    end
                end
                if (rinc) begin
                    pop_total++;
                    check("pop_nonempty", 32'(rempty), 32'd0);
                end
                if (done) begin
                    done_count++;
                    check("done_single", 32'(prev_done), 32'd0);
                end
            end
            prev_hold = m_valid && !m_ready && !rrst;
            prev_data = m_data;
            prev_last = m_last;
            prev_done = done && !rrst;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [3:0] pat;
        int p0, a0, d0;
        pat     = 4'b1001;
        rrst    = 1'b1;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b1;
        repeat (3) tick();
        @(negedge rclk);
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        rrst = 1'b0;
        tick();

        // Unstalled burst of 5 with cycle-exact timing
        push_fifo(8'h85); push_fifo(8'h77); push_fifo(8'h10); push_fifo(8'h90); push_fifo(8'hA0);
        expect_beat(8'h85, 0); expect_beat(8'h77, 0); expect_beat(8'h10, 0);
        expect_beat(8'h90, 0); expect_beat(8'hA0, 1);
        start = 1'b1;
        len   = 5'd5;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            @(negedge rclk);
            check("t1_rinc", 32'(rinc), 32'(c <= 5));
            check("t1_busy", 32'(busy), 32'(c <= 6));
            check("t1_done", 32'(done), 32'(c == 7));
            if (c == 1) check("t1_first_valid", 32'(m_valid), 32'd0);
        end
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Same burst with m_ready toggling 1,0,0,1
        push_fifo(8'h85); push_fifo(8'h77); push_fifo(8'h10); push_fifo(8'h90); push_fifo(8'hA0);
        expect_beat(8'h85, 0); expect_beat(8'h77, 0); expect_beat(8'h10, 0);
        expect_beat(8'h90, 0); expect_beat(8'hA0, 1);
        p0 = pop_total;
        a0 = acc_total;
        d0 = done_count;
        start = 1'b1;
        len   = 5'd5;
        tick();
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            m_ready = pat[c % 4];
            @(negedge rclk);
            check("t2_pop_ratio", 32'(((pop_total - p0) - (acc_total - a0)) <= 1), 32'd1);
            if (done_count != d0) break;
            tick();
        end
        check("t2_done_once", 32'(done_count - d0), 32'd1);
        check("t2_pops", 32'(pop_total - p0), 32'd5);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();
        m_ready = 1'b1;

        // FIFO underrun: 2 of 4 entries present, rest arrive later
        push_fifo(8'hC1); push_fifo(8'hC2);
        expect_beat(8'hC1, 0); expect_beat(8'hC2, 0); expect_beat(8'hC3, 0); expect_beat(8'hC4, 1);
        p0 = pop_total;
        start = 1'b1;
        len   = 5'd4;
        tick();
        start = 1'b0;
        repeat (6) tick();
        @(negedge rclk);
        check("t3_stall_rinc", 32'(rinc), 32'd0);
        check("t3_stall_busy", 32'(busy), 32'd1);
        check("t3_stall_pops", 32'(pop_total - p0), 32'd2);
        repeat (3) tick();
        push_fifo(8'hC3); push_fifo(8'hC4);
        wait_done(20, "t3_done");
        check("t3_pops", 32'(pop_total - p0), 32'd4);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Illegal lengths and start re-pulse during a burst
        push_fifo(8'hD1); push_fifo(8'hD2); push_fifo(8'hD3); push_fifo(8'hD4);
        p0 = pop_total;
        start = 1'b1;
        len   = 5'd0;
        tick();
        start = 1'b0;
        @(negedge rclk);
        check("t4_len0_busy", 32'(busy), 32'd0);
        check("t4_len0_rinc", 32'(rinc), 32'd0);
        tick();
        start = 1'b1;
        len   = 5'(MAX_BURST + 1);
        tick();
        start = 1'b0;
        @(negedge rclk);
        check("t4_lenmax_busy", 32'(busy), 32'd0);
        check("t4_lenmax_rinc", 32'(rinc), 32'd0);
        tick();
        expect_beat(8'hD1, 0); expect_beat(8'hD2, 0); expect_beat(8'hD3, 1);
        start = 1'b1;
        len   = 5'd3;
        tick();
        len   = 5'd2;
        tick();
        start = 1'b0;
        wait_done(20, "t4_done");
        check("t4_pops", 32'(pop_total - p0), 32'd3);
        check("t4_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
        tick();

        // Back-to-back single-beat bursts, start in the cycle after done
        push_fifo(8'hB1); push_fifo(8'hB2);
        expect_beat(8'hD4, 1); expect_beat(8'hB1, 1); expect_beat(8'hB2, 1);
        for (int b = 0; b < 3; b++) begin
            start = 1'b1;
            len   = 5'd1;
            tick();
            start = 1'b0;
            @(negedge rclk);
            check("t6_rinc", 32'(rinc), 32'd1);
            check("t6_busy", 32'(busy), 32'd1);
            tick();
            tick();
            @(negedge rclk);
            check("t6_done", 32'(done), 32'd1);
            tick();
        end
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset after the second pop of a 5-beat burst
        push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33); push_fifo(8'h44); push_fifo(8'h55);
        expect_beat(8'h11, 0);
        d0 = done_count;
        start = 1'b1;
        len   = 5'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        rrst    = 1'b1;
        m_ready = 1'b0;
        @(negedge rclk);
        check("t5_rinc_in_rst", 32'(rinc), 32'd0);
        tick();
        rrst    = 1'b0;
        m_ready = 1'b1;
        @(negedge rclk);
        check("t5_valid", 32'(m_valid), 32'd0);
        check("t5_last", 32'(m_last), 32'd0);
        check("t5_data", 32'(m_data), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rinc", 32'(rinc), 32'd0);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t5_fifo_left", 32'(wr_ptr - rd_ptr), 32'd3);
        repeat (3) tick();
        check("t5_no_done", 32'(done_count - d0), 32'd0);
        expect_beat(8'h33, 0); expect_beat(8'h44, 0); expect_beat(8'h55, 1);
        start = 1'b1;
        len   = 5'd3;
        tick();
        start = 1'b0;
        wait_done(20, "t5_done");
        check("t5_done_once", 32'(done_count - d0), 32'd1);
        repeat (2) tick();
        check("t5_sb_final", 32'(exp_q.size()), 32'd0);
        check("t5_fifo_empty", 32'(rempty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
